// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field widths, special encodings, unpacked operand type.
// Pure declarations; no logic, no latency.
// No flow control; consumers are combinational or pipelined FPU units.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      POS_INF = 32'h7F800000;
  localparam logic [31:0]      QNAN    = 32'h7FC00000;

  // Operand after decode: sign, biased exponent, 24-bit significand with hidden bit.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sig;
  } fp_unpacked_t;

  // Split a binary32 word; the hidden bit is 0 for exp==0 so flushed denormals
  // never contribute significand bits.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] f);
    fp_unpacked_t u;
    u.sign = f[31];
    u.exp  = f[30:23];
    u.sig  = {(f[30:23] != '0), f[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/lzc24.sv
// Leading-zero counter over the 27-bit {significand, guard, round, sticky} word.
// Combinational, 0 cycles.
// No flow control; output follows input within the same evaluation.
module lzc24 #(
  parameter int W = 27
) (
  input  logic [W-1:0] i_val,
  output logic [4:0]   o_cnt
);

  // Scan from LSB upward so the highest set bit wins; all-zero input yields W.
  always_comb begin
    o_cnt = 5'(W);
    for (int i = 0; i < W; i++) begin
      if (i_val[i]) o_cnt = 5'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fadd.sv
// Binary32 adder: align, add/sub, normalize, round-nearest-even; denormals flushed.
// Combinational, 0 cycles from x1/x2 to y/ovf; clk/rstn carried for uniform FPU port lists.
// No handshake; y/ovf are always a pure function of the current operands.
module fadd
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] y,
  output logic        ovf
);

  fp_unpacked_t w_a, w_b, w_l, w_s;
  logic         w_a_zero, w_a_inf, w_b_zero, w_b_inf;
  logic         w_swap, w_sub;
  logic [7:0]   w_diff;
  logic [49:0]  w_wide;
  logic [26:0]  w_big, w_small;
  logic [27:0]  w_sum;
  logic [4:0]   w_lz;
  logic [26:0]  w_norm;
  logic [9:0]   w_exp_n, w_exp_r;
  logic         w_up;
  logic [24:0]  w_rnd;
  logic [22:0]  w_frac;
  logic         w_unused;

  // Clock and reset have no state to drive in this combinational revision.
  assign w_unused = &{1'b0, clk, rstn};

  assign w_a      = fp_unpack(x1);
  assign w_b      = fp_unpack(x2);
  assign w_a_zero = (w_a.exp == '0);
  assign w_b_zero = (w_b.exp == '0);
  assign w_a_inf  = (w_a.exp == EXP_MAX);
  assign w_b_inf  = (w_b.exp == EXP_MAX);

  lzc24 u_lzc (
    .i_val (w_sum[26:0]),
    .o_cnt (w_lz)
  );

  // Order by magnitude, then align the smaller significand with guard/round/sticky.
  always_comb begin
    // For normal operands the {exp,man} bit pattern orders by magnitude.
    w_swap = (x2[30:0] > x1[30:0]);
    w_l    = w_swap ? w_b : w_a;
    w_s    = w_swap ? w_a : w_b;
    w_diff = w_l.exp - w_s.exp;
    w_wide = {w_s.sig, 26'b0} >> w_diff[4:0];
    w_big  = {w_l.sig, 3'b0};
    // Hidden bit is always set here, so a far-shifted operand still leaves sticky.
    if (w_diff >= 8'd26) w_small = 27'd1;
    else                 w_small = {w_wide[49:24], |w_wide[23:0]};
    w_sub  = w_l.sign ^ w_s.sign;
    w_sum  = w_sub ? ({1'b0, w_big} - {1'b0, w_small})
                   : ({1'b0, w_big} + {1'b0, w_small});
  end

  // Normalize: one right shift on carry-out, otherwise left by the leading-zero count.
  always_comb begin
    if (w_sum[27]) begin
      w_norm  = {w_sum[27:2], |w_sum[1:0]};
      w_exp_n = {2'b0, w_l.exp} + 10'd1;
    end else begin
      // Large left shifts only occur for diff<=1 where the sticky bit is zero.
      w_norm  = w_sum[26:0] << w_lz;
      w_exp_n = {2'b0, w_l.exp} - {5'b0, w_lz};
    end
  end

  // Round to nearest, ties to even; a carry out of the significand bumps the exponent.
  always_comb begin
    w_up    = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
    w_rnd   = {1'b0, w_norm[26:3]} + {24'b0, w_up};
    w_exp_r = w_exp_n + {9'b0, w_rnd[24]};
    w_frac  = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];
  end

  // Select special results ahead of the arithmetic path.
  always_comb begin
    y   = 32'h0;
    ovf = 1'b0;
    if (w_a_inf && w_b_inf) begin
      y = (w_a.sign != w_b.sign) ? QNAN : {w_a.sign, POS_INF[30:0]};
    end else if (w_a_inf) begin
      y = {w_a.sign, POS_INF[30:0]};
    end else if (w_b_inf) begin
      y = {w_b.sign, POS_INF[30:0]};
    end else if (w_a_zero && w_b_zero) begin
      y = {w_a.sign & w_b.sign, 31'b0};
    end else if (w_a_zero) begin
      y = x2;
    end else if (w_b_zero) begin
      y = x1;
    end else if (w_sum == '0) begin
      y = 32'h0;
    end else if (w_exp_r[9] || (w_exp_r == '0)) begin
      y = {w_l.sign, 31'b0};
    end else if (w_exp_r >= 10'd255) begin
      y   = {w_l.sign, POS_INF[30:0]};
      ovf = 1'b1;
    end else begin
      y = {w_l.sign, w_exp_r[7:0], w_frac};
    end
  end

endmodule

// File: tb/tb_fadd.sv
// Directed and randomized checks of fadd against a real-arithmetic reference.
module tb_fadd;

  logic        clk;
  logic        rstn;
  logic [31:0] x1, x2, y;
  logic        ovf;

  int n_pass  = 0;
  int n_total = 0;

  fadd dut (
    .clk  (clk),
    .rstn (rstn),
    .x1   (x1),
    .x2   (x2),
    .y    (y),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    x1 = a;
    x2 = b;
    #1;
  endtask

  task automatic dir(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ey, input logic eo);
    apply(a, b);
    chk({tag, ".y"}, y, ey);
    chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, eo});
  endtask

  // Value of a binary32 word with exp==0 read as zero.
  function automatic real f2r(input logic [31:0] f);
    int  e;
    real m;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return f[31] ? -m : m;
  endfunction

  // Random finite operand with denormals flushed to signed zero.
  function automatic logic [31:0] rnd_op();
    logic [31:0] f;
    f = $urandom;
    if (f[30:23] == 8'hFF) f[30:23] = 8'(1 + $urandom_range(253));
    if (f[30:23] == 8'h00) f = {f[31], 31'b0};
    return f;
  endfunction

  logic [31:0] a, b;
  logic [63:0] rb;
  real         r, absr, ulp, diff;
  int          de, fe, eb, n_skip;
  logic        ok;

  initial begin
    rstn = 1'b0;
    x1   = 32'h0;
    x2   = 32'h0;
    n_skip = 0;
    #2;
    // Reset has no effect on the combinational result.
    dir("rst_1p1", 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
    chk("rst_zero", y & 32'h0, 32'h0 & {32{rstn}});
    @(negedge clk);
    rstn = 1'b1;
    #1;

    dir("one_plus_one",  32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0);
    dir("cancel",        32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0);
    dir("tie_even",      32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
    dir("tie_odd_up",    32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0);
    dir("ovf_pos",       32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
    dir("ovf_neg",       32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 1'b1);
    dir("inf_plus_1",    32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0);
    dir("1_plus_ninf",   32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b0);
    dir("inf_man",       32'h7F800001, 32'h3F800000, 32'h7F800000, 1'b0);
    dir("inf_minus_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0);
    dir("zero_plus_3",   32'h00000000, 32'h40400000, 32'h40400000, 1'b0);
    dir("denorm_plus_1", 32'h00400000, 32'h3F800000, 32'h3F800000, 1'b0);
    dir("nz_plus_nz",    32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
    dir("nz_plus_pz",    32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    dir("massive_cancel",32'h3FC00000, 32'hBF800000, 32'h3F000000, 1'b0);
    dir("tie_big",       32'h4B000000, 32'h3F000000, 32'h4B000000, 1'b0);
    dir("underflow_neg", 32'h80800001, 32'h00800000, 32'h80000000, 1'b0);
    dir("sub_2_minus_1", 32'h40000000, 32'hBF800000, 32'h3F800000, 1'b0);

    // Random sweep; half the pairs have nearby exponents to exercise cancellation.
    for (int i = 0; i < 50000; i++) begin
      a = rnd_op();
      b = rnd_op();
      if (i[0] && a[30:23] != 8'h00) begin
        eb = int'(a[30:23]) + $urandom_range(4) - 2;
        if (eb < 1)   eb = 1;
        if (eb > 254) eb = 254;
        b[30:23] = 8'(eb);
        if (i[1]) b[31] = ~a[31];
        if (i[2]) b[22:8] = a[22:8];
      end
      apply(a, b);
      r = f2r(a) + f2r(b);
      if (a[30:23] == 8'h00 && b[30:23] == 8'h00) begin
        chk("rnd_zero_zero", y, {a[31] & b[31], 31'b0});
      end else if (r == 0.0) begin
        chk("rnd_exact_cancel", y, 32'h0);
        chk("rnd_cancel_ovf", {31'b0, ovf}, 32'h0);
      end else begin
        absr = (r < 0.0) ? -r : r;
        rb   = $realtobits(r);
        de   = int'(rb[62:52]) - 1023;
        fe   = de + 127;
        if (absr >= (2.0 ** 128) - (2.0 ** 103)) begin
          chk("rnd_ovf_y", y, {(r < 0.0), 8'hFF, 23'b0});
          chk("rnd_ovf_flag", {31'b0, ovf}, 32'h1);
        end else if (fe <= 0) begin
          n_skip++;
        end else begin
          ulp  = 2.0 ** (de - 23);
          diff = f2r(y) - r;
          if (diff < 0.0) diff = -diff;
          ok = (y[30:23] != 8'hFF) && (y[30:23] != 8'h00) && (diff <= ulp);
          n_total++;
          assert (ok) n_pass++;
          else $error("FAIL rnd_ulp a=%h b=%h observed=%h expected_real=%g", a, b, y, r);
          chk("rnd_no_ovf", {31'b0, ovf}, 32'h0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
